// File: rtl/alu_sequencer.sv
// alu_sequencer -- single-request ALU with a valid/ready handshake on each side.
//
// A request (op, a, b) is captured when in_valid and in_ready are both high.
// Non-divide ops finish in one EXEC cycle.
// Divide uses an 8-cycle restoring divider in the DIV state.
// The result is then held in DONE until out_ready is seen.
//
// Build option:
//   ALU_SEQ_DIV_EN  defined   -> DIV state and divider are built.
//                   undefined -> op=div is reported as illegal (err=1).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request present
//   in_ready   block accepts a request this cycle (IDLE only)
//   op[2:0]    000 add, 001 sub, 010 mul, 011 div, 100 eq, 101 gt, 110 lt,
//              111 illegal
//   a[7:0]     unsigned operand A
//   b[7:0]     unsigned operand B
//   out_valid  result present
//   out_ready  consumer accepts the result
//   result     16-bit result; for div, {remainder, quotient}
//   div_zero   set with the result for a divide by zero
//   err        set with the result for an illegal or unsupported op
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        div_zero,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;
  localparam logic [2:0] OP_GT  = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;

  logic [15:0] exec_result;
  logic        exec_err;
  logic        exec_dz;
  logic [7:0]  sum8;
  logic [7:0]  diff8;

  assign in_ready = (state == IDLE) && !rst;

  assign sum8  = a_q + b_q;
  assign diff8 = a_q - b_q;

  // Single-cycle datapath, evaluated on the captured operands.
  always_comb begin
    exec_result = '0;
    exec_err    = 1'b0;
    exec_dz     = 1'b0;
    case (op_q)
      OP_ADD: exec_result = {8'h00, sum8};
      OP_SUB: exec_result = {8'h00, diff8};
      OP_MUL: exec_result = {8'h00, a_q} * {8'h00, b_q};
      OP_EQ:  exec_result = {15'd0, a_q == b_q};
      OP_GT:  exec_result = {15'd0, a_q >  b_q};
      OP_LT:  exec_result = {15'd0, a_q <  b_q};
`ifdef ALU_SEQ_DIV_EN
      // Only b == 0 reaches EXEC with a divide; the other divides go to DIV.
      OP_DIV: exec_dz = 1'b1;
      OP_ILL: exec_err = 1'b1;
`else
      OP_DIV, OP_ILL: exec_err = 1'b1;
`endif
      default: exec_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  logic [3:0] cnt;
  logic [7:0] rem;
  logic [7:0] quo;
  logic [8:0] trial;
  logic [8:0] trial_sub;
  logic       q_bit;
  logic [7:0] rem_next;
  logic [7:0] quo_next;

  // One restoring step.
  // Shift the next dividend bit (the MSB of quo) into the partial remainder.
  // Subtract the divisor if it fits.
  // The dividend drains out of quo as the quotient bits fill in.
  assign trial     = {rem, quo[7]};
  assign trial_sub = trial - {1'b0, b_q};
  assign q_bit     = (trial >= {1'b0, b_q});
  assign rem_next  = q_bit ? trial_sub[7:0] : trial[7:0];
  assign quo_next  = {quo[6:0], q_bit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      div_zero  <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
`ifdef ALU_SEQ_DIV_EN
            if (op == OP_DIV && b != 8'd0) begin
              state <= DIV;
              cnt   <= '0;
              rem   <= '0;
              quo   <= a;
            end else begin
              state <= EXEC;
            end
`else
            state <= EXEC;
`endif
          end
        end
        EXEC: begin
          result    <= exec_result;
          err       <= exec_err;
          div_zero  <= exec_dz;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            result    <= {rem_next, quo_next};
            err       <= 1'b0;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            err       <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
